// File: rtl/four_out_demux_seq.sv
// Four-lane demultiplexer with per-lane holding registers and valid/ready handshake.
// Lane chosen by select input or by a round-robin pointer that advances on accepts.
module four_out_demux_seq #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [1:0]   s,
  input  logic         mode,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [7:0]   xfer_cnt
);

  localparam int unsigned NumLanes = 4;

  logic [W-1:0] r_data [NumLanes];
  logic [3:0]   r_valid;
  logic [1:0]   r_rr;
  logic [7:0]   r_cnt;

  logic [1:0]   w_tgt;
  logic         w_accept;
  logic [3:0]   w_load;
  logic [3:0]   w_deliver;
  logic [3:0]   w_valid_d;
  logic [1:0]   w_rr_d;
  logic [7:0]   w_cnt_d;

  always_comb begin
    w_tgt     = mode ? r_rr : s;
    // A full lane can still take a word in the same cycle it drains.
    i_ready   = ~r_valid[w_tgt] | out_ready[w_tgt];
    w_accept  = i_valid & i_ready;
    w_load    = 4'b0000;
    if (w_accept) begin
      w_load[w_tgt] = 1'b1;
    end
    w_deliver = r_valid & out_ready;
  end

  always_comb begin
    w_valid_d = (r_valid & ~w_deliver) | w_load;
    w_rr_d    = r_rr;
    w_cnt_d   = r_cnt;
    if (w_accept) begin
      w_cnt_d = r_cnt + 8'd1;
      if (mode) begin
        w_rr_d = r_rr + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 4'b0000;
      r_rr    <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_valid <= w_valid_d;
      r_rr    <= w_rr_d;
      r_cnt   <= w_cnt_d;
    end
  end

  for (genvar k = 0; k < NumLanes; k++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data[k] <= '0;
      end else if (w_load[k]) begin
        r_data[k] <= i;
      end
    end
  end

  assign out0      = r_data[0];
  assign out1      = r_data[1];
  assign out2      = r_data[2];
  assign out3      = r_data[3];
  assign out_valid = r_valid;
  assign xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_four_out_demux_seq.sv
// Bench for four_out_demux_seq: directed literal scenarios plus randomized traffic,
// all checked every cycle against a lane/queue model of the demux behaviour.
module tb_four_out_demux_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] i;
  logic         i_valid;
  logic         i_ready;
  logic [1:0]   s;
  logic         mode;
  logic [W-1:0] out0, out1, out2, out3;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [7:0]   xfer_cnt;

  int n_tot = 0;
  int n_bad = 0;

  four_out_demux_seq #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i        (i),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .s        (s),
    .mode     (mode),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: each lane is a one-deep slot; pointer and count are plain integers.
  int  m_data [4];
  bit  m_full [4];
  int  m_ptr;
  int  m_cnt;
  bit  m_init = 0;

  function automatic int m_target();
    return mode ? m_ptr : int'(s);
  endfunction

  function automatic bit m_ready();
    int t;
    t = m_target();
    return !m_full[t] || out_ready[t];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_data[k] = 0;
        m_full[k] = 0;
      end
      m_ptr  = 0;
      m_cnt  = 0;
      m_init = 1;
    end else if (m_init) begin
      int  t;
      bit  acc;
      t   = m_target();
      acc = i_valid && m_ready();
      for (int k = 0; k < 4; k++) begin
        if (m_full[k] && out_ready[k]) m_full[k] = 0;
      end
      if (acc) begin
        m_data[t] = int'(i);
        m_full[t] = 1;
        m_cnt     = (m_cnt + 1) % 256;
        if (mode) m_ptr = (m_ptr + 1) % 4;
      end
    end
  end

  // Compare process: registered outputs and combinational i_ready, mid-cycle.
  always @(negedge clk) begin
    if (m_init) begin
      int vexp;
      vexp = 0;
      for (int k = 0; k < 4; k++) vexp |= (int'(m_full[k]) << k);
      chk("model_out0", int'(out0), m_data[0]);
      chk("model_out1", int'(out1), m_data[1]);
      chk("model_out2", int'(out2), m_data[2]);
      chk("model_out3", int'(out3), m_data[3]);
      chk("model_out_valid", int'(out_valid), vexp);
      chk("model_xfer_cnt", int'(xfer_cnt), m_cnt);
      chk("model_i_ready", int'(i_ready), int'(m_ready()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int lane_v;
    rst = 1'b1; i = '0; i_valid = 1'b0; s = 2'd0; mode = 1'b0; out_ready = 4'b0000;
    tick();
    rst = 1'b0;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_xfer_cnt", int'(xfer_cnt), 0);
    chk("reset_out0", int'(out0), 0);

    // Select-mode single word into lane 2.
    mode = 1'b0; s = 2'd2; i = 4'hA; i_valid = 1'b1; out_ready = 4'b0000;
    #1 chk("sel_i_ready", int'(i_ready), 1);
    tick();
    i_valid = 1'b0;
    chk("sel_out2", int'(out2), 10);
    chk("sel_out_valid", int'(out_valid), 4);
    chk("sel_xfer", int'(xfer_cnt), 1);
    chk("sel_out0_untouched", int'(out0), 0);

    // Round-robin with all sinks ready: 1..5 land in lanes 0,1,2,3,0.
    do_reset();
    mode = 1'b1; out_ready = 4'b1111;
    for (int n = 1; n <= 5; n++) begin
      i = W'(n); i_valid = 1'b1;
      tick();
      lane_v = 1 << ((n - 1) % 4);
      chk("rr_out_valid", int'(out_valid), lane_v);
    end
    chk("rr_out0_last", int'(out0), 5);
    chk("rr_out3", int'(out3), 4);
    chk("rr_xfer", int'(xfer_cnt), 5);
    i = 4'd6;
    tick();
    chk("rr_ptr_is1", int'(out1), 6);
    chk("rr_ptr_valid", int'(out_valid), 2);
    i_valid = 1'b0;

    // Lane 1 full and stalled, then released while loading.
    do_reset();
    mode = 1'b0; s = 2'd1; i = 4'd3; i_valid = 1'b1; out_ready = 4'b0000;
    tick();
    i = 4'd7;
    #1 chk("stall_i_ready", int'(i_ready), 0);
    tick();
    chk("stall_out1_held", int'(out1), 3);
    chk("stall_xfer", int'(xfer_cnt), 1);
    out_ready = 4'b0010;
    #1 chk("drain_i_ready", int'(i_ready), 1);
    tick();
    i_valid = 1'b0; out_ready = 4'b0000;
    chk("drain_out1", int'(out1), 7);
    chk("drain_out_valid", int'(out_valid), 2);
    chk("drain_xfer", int'(xfer_cnt), 2);

    // Round-robin wraps onto a stalled lane 0 and must not skip.
    do_reset();
    mode = 1'b1; out_ready = 4'b0000; i_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      i = W'(n + 1);
      tick();
    end
    i = 4'hE;
    for (int n = 0; n < 3; n++) begin
      #1 chk("rrstall_i_ready", int'(i_ready), 0);
      tick();
    end
    chk("rrstall_out1", int'(out1), 2);
    chk("rrstall_xfer", int'(xfer_cnt), 4);
    out_ready = 4'b0001;
    tick();
    i_valid = 1'b0; out_ready = 4'b0000;
    chk("rrstall_out0_new", int'(out0), 14);
    chk("rrstall_out_valid", int'(out_valid), 15);

    // Reset with a word presented discards everything.
    do_reset();
    mode = 1'b0; s = 2'd0; i = 4'd5; i_valid = 1'b1;
    tick();
    s = 2'd3; i = 4'd6;
    tick();
    rst = 1'b1; i = 4'd9;
    tick();
    rst = 1'b0; i_valid = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out0", int'(out0), 0);
    chk("rst_out3", int'(out3), 0);
    chk("rst_xfer", int'(xfer_cnt), 0);
    mode = 1'b1; i = 4'hB; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("rst_rr_lane0", int'(out0), 11);
    chk("rst_rr_valid", int'(out_valid), 1);

    // Counter wrap at 256 accepts.
    do_reset();
    mode = 1'b0; out_ready = 4'b1111; i_valid = 1'b1;
    for (int n = 0; n < 255; n++) begin
      s = 2'($urandom_range(0, 3));
      i = W'($urandom);
      tick();
    end
    chk("wrap_255", int'(xfer_cnt), 255);
    tick();
    chk("wrap_0", int'(xfer_cnt), 0);
    i_valid = 1'b0;

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      i         = W'($urandom);
      i_valid   = ($urandom_range(0, 3) != 0);
      s         = 2'($urandom_range(0, 3));
      mode      = ($urandom_range(0, 7) < 3) ? ~mode : mode;
      out_ready = 4'($urandom) & 4'($urandom);
      tick();
    end
    rst = 1'b0; i_valid = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
